score_keeper: RTL

- Game-flow controller directly downstream of the ball motion block.
- Consumes the ball block's one-cycle point pulses, keeps both players' scores in 2-digit BCD and runs the serve/play/game-over sequence.
- Drives the ball block's active-high reset (ball_hold) so that the ball stays parked during serve delays and after the match ends.
- Score outputs feed the on-screen digit renderer.

---
 rtl/pong_pkg.sv | 29 ++
 rtl/bcd_counter_2d.sv | 27 ++
 rtl/score_keeper.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game-flow blocks.
package pong_pkg;

  localparam int SCORE_W     = 8;
  localparam int SERVE_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    OVER  = 2'b11
  } state_t;

  // Two-digit BCD increment; 99 wraps to 00, which the win limit never reaches.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] value);
    logic [3:0] ones;
    logic [3:0] tens;
    ones = value[3:0];
    tens = value[7:4];
    if (ones == 4'd9) begin
      ones = 4'd0;
      tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      ones = ones + 4'd1;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_counter_2d.sv
// Two-digit BCD up-counter with synchronous clear; clear beats increment.
module bcd_counter_2d
  import pong_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] value
);

  logic [SCORE_W-1:0] r_value;

  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= bcd_inc(r_value);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/score_keeper.sv
// Game-flow controller: counts points in BCD, times serves and parks the ball between rallies.
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 11,
  parameter int SERVE_TICKS = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               point_1,
  input  logic               point_2,
  output logic               ball_hold,
  output logic [SCORE_W-1:0] score_1,
  output logic [SCORE_W-1:0] score_2,
  output logic               playing,
  output logic               game_over,
  output logic               winner
);

  localparam logic [3:0]             WIN_TENS   = 4'(WIN_SCORE / 10);
  localparam logic [3:0]             WIN_ONES   = 4'(WIN_SCORE % 10);
  localparam logic [SERVE_CNT_W-1:0] SERVE_LOAD = SERVE_CNT_W'(SERVE_TICKS - 1);

  if (WIN_SCORE < 1 || WIN_SCORE > 99) begin : g_bad_win_score
    $error("score_keeper: WIN_SCORE must be in 1..99");
  end
  if (SERVE_TICKS < 1 || SERVE_TICKS > 65535) begin : g_bad_serve_ticks
    $error("score_keeper: SERVE_TICKS must be in 1..65535");
  end

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SERVE_CNT_W-1:0] r_serve_cnt;
  logic [SERVE_CNT_W-1:0] w_serve_cnt_next;
  logic                   r_start_q;
  logic                   w_start_rise;
  logic                   r_winner;
  logic                   w_winner_next;
  logic                   r_ball_hold;
  logic                   r_playing;
  logic                   r_game_over;
  logic                   w_clr;
  logic                   w_inc_1;
  logic                   w_inc_2;
  logic                   w_win_1;
  logic                   w_win_2;
  logic [SCORE_W-1:0]     w_score_1;
  logic [SCORE_W-1:0]     w_score_2;

  assign w_start_rise = start & ~r_start_q;

  // The win test looks at the score this point would produce, so OVER is entered on the scoring edge.
  assign w_win_1 = (bcd_inc(w_score_1) == {WIN_TENS, WIN_ONES});
  assign w_win_2 = (bcd_inc(w_score_2) == {WIN_TENS, WIN_ONES});

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next     = r_state;
    w_serve_cnt_next = r_serve_cnt;
    w_winner_next    = r_winner;
    w_clr            = 1'b0;
    w_inc_1          = 1'b0;
    w_inc_2          = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_start_rise) begin
          w_serve_cnt_next = SERVE_LOAD;
          w_state_next     = SERVE;
        end
      end
      SERVE: begin
        if (r_serve_cnt == '0) begin
          w_state_next = PLAY;
        end else begin
          w_serve_cnt_next = r_serve_cnt - 1'b1;
        end
      end
      PLAY: begin
        if (point_1) begin
          w_inc_1 = 1'b1;
          if (w_win_1) begin
            w_winner_next = 1'b0;
            w_state_next  = OVER;
          end else begin
            w_serve_cnt_next = SERVE_LOAD;
            w_state_next     = SERVE;
          end
        end else if (point_2) begin
          w_inc_2 = 1'b1;
          if (w_win_2) begin
            w_winner_next = 1'b1;
            w_state_next  = OVER;
          end else begin
            w_serve_cnt_next = SERVE_LOAD;
            w_state_next     = SERVE;
          end
        end
      end
      OVER: begin
        if (w_start_rise) begin
          w_clr            = 1'b1;
          w_serve_cnt_next = SERVE_LOAD;
          w_state_next     = SERVE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_serve_cnt <= '0;
      r_start_q   <= 1'b0;
      r_winner    <= 1'b0;
      r_ball_hold <= 1'b1;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_serve_cnt <= w_serve_cnt_next;
      r_start_q   <= start;
      r_winner    <= w_winner_next;
      r_ball_hold <= (w_state_next != PLAY);
      r_playing   <= (w_state_next == PLAY);
      r_game_over <= (w_state_next == OVER);
    end
  end

  bcd_counter_2d u_score_1 (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_inc_1),
    .value (w_score_1)
  );

  bcd_counter_2d u_score_2 (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .inc   (w_inc_2),
    .value (w_score_2)
  );

  assign ball_hold = r_ball_hold;
  assign playing   = r_playing;
  assign game_over = r_game_over;
  assign winner    = r_winner;
  assign score_1   = w_score_1;
  assign score_2   = w_score_2;

endmodule
